// File: rtl/bin_to_bcd_seq_pkg.sv
// bcd_pkg: shared types and constants for the BCD datapath blocks.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: operand and result handshakes of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(parameter int BIN_W = 8, parameter int DIGITS = 3);
  logic in_valid;
  logic in_ready;
  logic [BIN_W-1:0] in_bin;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic out_ovf;
  modport master (output in_valid, in_bin, out_ready, input in_ready, out_valid, out_bcd, out_ovf);
  modport slave (input in_valid, in_bin, out_ready, output in_ready, out_valid, out_bcd, out_ovf);
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a digit of 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);
  always_comb d_o = d_i >= ADJ_THRESH ? d_i + ADJ_ADD : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with overflow flag.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int DIGITS = 3
) (
  input logic CLOCK_50,
  input logic rst_n,
  bin_to_bcd_seq_if.slave io
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W) + 1;
  state_e state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [W-1:0] bcd_q, bcd_d, adj;
  logic ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, shifting;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (.d_i(bcd_q[BCD_DIGIT_W*d +: BCD_DIGIT_W]), .d_o(adj[BCD_DIGIT_W*d +: BCD_DIGIT_W]));
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (io.in_valid ? SHIFT : IDLE) :
              state_q == SHIFT ? (cnt_q == CW'(BIN_W - 1) ? DONE : SHIFT) :
              state_q == DONE  ? (io.out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    io.in_ready  = state_q == IDLE;
    io.out_valid = state_q == DONE;
    io.out_bcd   = bcd_q;
    io.out_ovf   = ovf_q;
  end
  // Adjusted digits shift left with the next binary bit; a bit leaving the top digit is overflow.
  always_comb begin
    accept   = state_q == IDLE && io.in_valid;
    shifting = state_q == SHIFT;
    bin_d = accept ? io.in_bin : shifting ? bin_q << 1 : bin_q;
    bcd_d = accept ? '0 : shifting ? {adj[W-2:0], bin_q[BIN_W-1]} : bcd_q;
    ovf_d = accept ? 1'b0 : shifting ? ovf_q | adj[W-1] : ovf_q;
    cnt_d = accept ? '0 : shifting ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: drives a 3-digit and a 2-digit converter in lockstep and checks both.
module tb_bin_to_bcd_seq;
  logic clk = 0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) a ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b ();
  assign b.in_valid = a.in_valid;
  assign b.in_bin = a.in_bin;
  assign b.out_ready = a.out_ready;
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.CLOCK_50(clk), .rst_n(rst_n), .io(a));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.CLOCK_50(clk), .rst_n(rst_n), .io(b));

  typedef struct {
    int bin;
    logic [11:0] bcd3;
    logic [7:0] bcd2;
    logic ovf2;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v, input int nd);
    logic [11:0] r = '0;
    int x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion: present v, wait for acceptance, measure latency, optionally stall the result.
  task automatic op(input int v, input int stall, input bit keep, output logic [11:0] r3, output logic o3,
                    output logic [7:0] r2, output logic o2, output int acc);
    int n, lat, bad;
    a.in_bin = 8'(v);
    a.in_valid = 1;
    a.out_ready = stall == 0;
    n = 0;
    while (!a.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", a.in_ready, 1);
    @(negedge clk);
    acc = cyc;
    if (!keep) a.in_valid = 0;
    lat = 1;
    bad = 0;
    while (!a.out_valid && lat < 50) begin
      bad += a.in_ready;
      @(negedge clk);
      lat++;
    end
    bad += a.in_ready;
    chk("latency", lat, 9);
    chk("busy_ready", bad, 0);
    r3 = a.out_bcd;
    o3 = a.out_ovf;
    r2 = b.out_bcd;
    o2 = b.out_ovf;
    if (stall > 0) begin
      a.in_bin = 8'd42;
      a.in_valid = 1;
      bad = 0;
      repeat (stall) begin
        @(negedge clk);
        bad += int'(!a.out_valid || a.in_ready || a.out_bcd !== r3 || b.out_bcd !== r2);
      end
      chk("hold_stable", bad, 0);
      a.in_valid = 0;
      a.out_ready = 1;
    end
    @(negedge clk);
    chk("idle_ready", a.in_ready, 1);
    chk("idle_valid", a.out_valid, 0);
  endtask

  logic [11:0] r3;
  logic [7:0] r2;
  logic o3, o2;
  int acc, prev_acc, bad;

  initial begin
    vecs[0] = '{255, 12'h255, 8'h55, 1'b1};
    vecs[1] = '{0,   12'h000, 8'h00, 1'b0};
    vecs[2] = '{9,   12'h009, 8'h09, 1'b0};
    vecs[3] = '{10,  12'h010, 8'h10, 1'b0};
    vecs[4] = '{99,  12'h099, 8'h99, 1'b0};
    vecs[5] = '{100, 12'h100, 8'h00, 1'b1};
    vecs[6] = '{200, 12'h200, 8'h00, 1'b1};
    vecs[7] = '{137, 12'h137, 8'h37, 1'b1};
    rst_n = 0;
    a.in_valid = 0;
    a.in_bin = '0;
    a.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_bcd3", a.out_bcd, 0);
    chk("rst_ovf3", a.out_ovf, 0);
    chk("rst_bcd2", b.out_bcd, 0);
    chk("rst_ovf2", b.out_ovf, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      op(vecs[i].bin, 0, 0, r3, o3, r2, o2, acc);
      chk($sformatf("vec%0d_bcd3", i), r3, vecs[i].bcd3);
      chk($sformatf("vec%0d_ovf3", i), o3, 0);
      chk($sformatf("vec%0d_bcd2", i), r2, vecs[i].bcd2);
      chk($sformatf("vec%0d_ovf2", i), o2, vecs[i].ovf2);
    end
    // Back-to-back with in_valid and out_ready held high: interval must be BIN_W+2.
    for (int i = 1; i <= 5; i++) begin
      op(vecs[i].bin, 0, i < 5, r3, o3, r2, o2, acc);
      chk($sformatf("b2b%0d_bcd3", i), r3, vecs[i].bcd3);
      if (i > 1) chk($sformatf("b2b%0d_ii", i), acc - prev_acc, 10);
      prev_acc = acc;
    end
    op(137, 20, 0, r3, o3, r2, o2, acc);
    chk("hold_bcd3", r3, 12'h137);
    op(42, 0, 0, r3, o3, r2, o2, acc);
    chk("after_hold_bcd3", r3, 12'h042);
    // Asynchronous abort during the shift phase.
    a.in_bin = 8'd200;
    a.in_valid = 1;
    a.out_ready = 1;
    @(negedge clk);
    a.in_valid = 0;
    repeat (4) @(negedge clk);
    chk("abort_busy", a.in_ready, 0);
    #1 rst_n = 0;
    #1;
    chk("abort_in_ready", a.in_ready, 1);
    chk("abort_out_valid", a.out_valid, 0);
    chk("abort_bcd3", a.out_bcd, 0);
    chk("abort_ovf2", b.out_ovf, 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      bad += a.out_valid + b.out_valid;
    end
    chk("abort_no_result", bad, 0);
    op(7, 0, 0, r3, o3, r2, o2, acc);
    chk("after_abort_bcd3", r3, 12'h007);
    // Full sweep against the decimal reference with random result stalls.
    for (int v = 0; v < 256; v++) begin
      op(v, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 5)) : 0, 0, r3, o3, r2, o2, acc);
      chk($sformatf("sweep%0d_bcd3", v), r3, ref_bcd(v, 3));
      chk($sformatf("sweep%0d_ovf3", v), o3, 0);
      chk($sformatf("sweep%0d_bcd2", v), r2, ref_bcd(v, 2));
      chk($sformatf("sweep%0d_ovf2", v), o2, v >= 100);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
